fir_tap_sequencer: RTL
======================

// Module: fir_tap_sequencer
// PURPOSE
//   Upstream feeder for the mac_unit FIR datapath. It accepts one input sample at a time
//   and keeps the last NUM_TAPS samples in a circular delay line. It holds NUM_TAPS
//   coefficients. For every accepted sample it issues one clear beat, then NUM_TAPS
//   (x[n-k], h[k]) beats on the MAC interface, so the downstream MAC accumulates y[n].
// PARAMETERS
//   DATA_WIDTH   18  sample width; matches MAC data_in
//   COEFF_WIDTH  18  coefficient width; matches MAC coeff
//   NUM_TAPS     16  filter length; any value >=2, not required to be a power of two
//   AW           $clog2(NUM_TAPS) localparam, tap/pointer index width
// PORTS
//   clk            in   1            clock
//   rst_n          in   1            reset, asynchronous, active-low
//   enable         in   1            run/freeze
//   s_data         in   DATA_WIDTH   input sample
//   s_valid        in   1            sample valid
//   s_ready        out  1            sample accepted when s_valid & s_ready & enable
//   coeff_wr_en    in   1            coefficient write strobe
//   coeff_wr_addr  in   AW           tap index k (values >= NUM_TAPS are ignored)
//   coeff_wr_data  in   COEFF_WIDTH  h[k]
//   coeff_wr_drop  out  1            1-cycle pulse: write rejected (busy or bad addr)
//   mac_data       out  DATA_WIDTH   to MAC data_in
//   mac_coeff      out  COEFF_WIDTH  to MAC coeff
//   mac_valid      out  1            to MAC data_valid
//   mac_ready      in   1            from MAC data_ready
//   mac_clear      out  1            to MAC clear_acc; high only on the clear beat
//   mac_last       out  1            high on the final tap beat of a frame
//   busy           out  1            FSM not in IDLE
//   sample_count   out  16           accepted samples, wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset values: all outputs 0. Delay line and coefficient array are 0. wr_ptr=0. FSM=IDLE.
//   - All outputs are registered.
//   - s_ready next value = enable & (next_state==IDLE). It first goes high one edge after reset release.
//   - FSM states: IDLE -> CLEAR -> TAPS -> IDLE.
//   - IDLE, on accept:
//       * write s_data to dline[wr_ptr]
//       * rd_ptr <= wr_ptr; wr_ptr <= (wr_ptr==NUM_TAPS-1) ? 0 : wr_ptr+1
//       * sample_count++; go CLEAR
//   - CLEAR: mac_valid=1, mac_clear=1, mac_data=0, mac_coeff=0. Go TAPS with k=0 on mac_ready.
//   - TAPS, beat k:
//       * mac_data=dline[rd_ptr], mac_coeff=h[k], mac_clear=0, mac_last=(k==NUM_TAPS-1)
//       * on mac_ready: k++, rd_ptr decrements; rd_ptr==0 wraps to NUM_TAPS-1
//       * after the last beat: go IDLE
//   - Handshake: a beat completes when mac_valid & mac_ready.
//       * While mac_ready=0, every mac_* output holds stable.
//       * No beat is skipped or repeated.
//   - enable=0: mac_valid is forced 0 on the next edge. FSM, k, pointers and data hold.
//     Restoring enable resumes the same beat.
//   - Timing (mac_ready=1, enable=1), sample accepted at edge t:
//       * clear beat in cycle t+1
//       * taps in cycles t+2 .. t+NUM_TAPS+1
//       * s_ready high again in cycle t+NUM_TAPS+2
//     Throughput is 1 sample per NUM_TAPS+2 cycles.
//   - Coefficient writes apply at the next edge, only when busy=0 and addr<NUM_TAPS.
//     Otherwise the write is ignored and coeff_wr_drop pulses. A frame therefore always
//     uses one consistent coefficient set.
//   - Reset asserted mid-frame: immediate return to reset values. The partial frame is
//     discarded; no mac_last is issued.
//   - No arithmetic is done here. Widths are passed through unchanged, signed interpretation
//     is left to the MAC.
// TESTING
//   1 NUM_TAPS=4, h={1,2,3,4}, samples 1,0,0,0 -> frame n MAC sums = h[n]: 1,2,3,4.
//     Each frame has exactly 1 clear beat + 4 tap beats, mac_last on beat 4.
//   2 Samples 10..15 (6 samples, NUM_TAPS=4) -> frame 6 mac_data order 15,14,13,12.
//     This covers pointer wrap; frames 1-3 use zero-filled history.
//   3 mac_ready=0 for 3 cycles at tap 2 -> mac_data/mac_coeff/mac_last stable.
//     Tap 2 is issued once, then tap 3 follows; s_ready stays 0.
//   4 coeff write h[1]=7 while busy -> coeff_wr_drop=1 for 1 cycle, h[1] unchanged.
//     Same write in IDLE -> next frame's tap 1 shows coeff 7.
//   5 enable=0 for 5 cycles mid-TAPS -> mac_valid=0 during the gap.
//     Resumes at the same k; the total frame beat count is unchanged.
//   6 rst_n pulse during TAPS -> all outputs 0 and sample_count=0.
//     The next sample sees zero history; the first output equals h[0]*x.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: circular delay line and coefficient store that streams one clear beat
// followed by NUM_TAPS (x[n-k], h[k]) beats per accepted sample to a downstream MAC.
module fir_tap_sequencer #(
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int NUM_TAPS    = 16,
    localparam int AW = $clog2(NUM_TAPS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   coeff_wr_en,
    input  logic [AW-1:0]          coeff_wr_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_wr_data,
    output logic                   coeff_wr_drop,
    output logic [DATA_WIDTH-1:0]  mac_data,
    output logic [COEFF_WIDTH-1:0] mac_coeff,
    output logic                   mac_valid,
    input  logic                   mac_ready,
    output logic                   mac_clear,
    output logic                   mac_last,
    output logic                   busy,
    output logic [15:0]            sample_count
);
    typedef enum logic [1:0] {IDLE, CLEAR, TAPS} state_t;
    localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

    state_t                 r_state, w_state_n;
    logic [AW-1:0]          r_k, w_k_n, r_rd_ptr, w_rd_n, r_wr_ptr;
    logic [DATA_WIDTH-1:0]  r_dline [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] r_coeff [NUM_TAPS];
    logic                   w_acc, w_fire, w_coeff_ok, w_valid_n;

    assign w_acc      = s_valid & s_ready & enable;
    // A beat the MAC has seen must advance even if enable drops in that cycle.
    assign w_fire     = mac_valid & mac_ready;
    assign w_coeff_ok = coeff_wr_en & ~busy & (32'(coeff_wr_addr) < NUM_TAPS);
    assign w_valid_n  = enable & (w_state_n != IDLE);

    always_comb begin
        w_state_n = r_state;
        w_k_n     = r_k;
        w_rd_n    = r_rd_ptr;
        case (r_state)
            IDLE: if (w_acc) begin
                w_state_n = CLEAR;
                w_rd_n    = r_wr_ptr;
            end
            CLEAR: if (w_fire) begin
                w_state_n = TAPS;
                w_k_n     = '0;
            end
            TAPS: if (w_fire) begin
                w_state_n = (r_k == LAST) ? IDLE : TAPS;
                w_k_n     = (r_k == LAST) ? '0 : r_k + AW'(1);
                w_rd_n    = (r_rd_ptr == '0) ? LAST : r_rd_ptr - AW'(1);
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            sample_count  <= '0;
            coeff_wr_drop <= 1'b0;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
            mac_valid     <= 1'b0;
            mac_clear     <= 1'b0;
            mac_last      <= 1'b0;
            mac_data      <= '0;
            mac_coeff     <= '0;
        end else begin
            r_state       <= w_state_n;
            r_k           <= w_k_n;
            r_rd_ptr      <= w_rd_n;
            if (w_acc) begin
                r_wr_ptr     <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
                sample_count <= sample_count + 16'd1;
            end
            coeff_wr_drop <= coeff_wr_en & ~w_coeff_ok;
            s_ready       <= enable & (w_state_n == IDLE);
            busy          <= w_state_n != IDLE;
            mac_valid     <= w_valid_n;
            mac_clear     <= w_valid_n & (w_state_n == CLEAR);
            mac_last      <= w_valid_n & (w_state_n == TAPS) & (w_k_n == LAST);
            mac_data      <= (w_state_n == TAPS) ? r_dline[w_rd_n] : '0;
            mac_coeff     <= (w_state_n == TAPS) ? r_coeff[w_k_n] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_dline[i] <= '0;
                r_coeff[i] <= '0;
            end
        end else begin
            if (w_acc) r_dline[r_wr_ptr] <= s_data;
            if (w_coeff_ok) r_coeff[coeff_wr_addr] <= coeff_wr_data;
        end
    end
endmodule
